// File: rtl/instr_aligner_pkg.sv
// Shared types for the fetch-to-decode instruction aligner.
// Holds the fetch halfword type, the aligned instruction type, the stored
// buffer entry type and the default buffer depth.
package instr_aligner_pkg;

   localparam int FETCH_W       = 8;
   localparam int BUF_DEPTH_DEF = 16;

   typedef logic [3:0] FetchID_t;

   typedef struct packed {
      logic [15:0] instr;
      logic [31:0] pc;
      logic        valid;
      FetchID_t    fetchID;
      logic        predTaken;
   } IF_Instr;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      FetchID_t    fetchID;
      logic        predTaken;
      logic        compressed;
      logic        illegal;
      logic        valid;
   } AlignedInstr_t;

   // One buffered halfword; validity is implied by its position in the buffer.
   typedef struct packed {
      logic [15:0] instr;
      logic [31:0] pc;
      FetchID_t    fetchID;
      logic        predTaken;
   } hw_entry_t;

endpackage

// File: rtl/instr_aligner_hw_fifo.sv
// Circular halfword buffer with multi-push and multi-pop per cycle.
// Pointers carry one extra bit so full and empty stay distinct across wrap.
// A clear empties the buffer and wins over any same-cycle push or pop.
module hw_fifo
   import instr_aligner_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int PUSH_W  = 8,
   parameter int PEEK_W  = 6,
   parameter int PUSH_CW = 4,
   parameter int POP_CW  = 3,
   parameter int PTR_W   = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic [PUSH_CW-1:0] push_cnt,
   input  hw_entry_t          push_data [PUSH_W],
   input  logic [POP_CW-1:0]  pop_cnt,
   output hw_entry_t          peek [PEEK_W],
   output logic [PTR_W-1:0]   count
);

   localparam int AW = $clog2(DEPTH);

   hw_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Store the compacted push entries starting at the write pointer.
   always_ff @(posedge clk) begin
      for (int i = 0; i < PUSH_W; i++) begin
         if (i < int'(push_cnt)) begin
            mem[wr_ptr[AW-1:0] + AW'(i)] <= push_data[i];
         end
      end
   end

   // Advance pointers by pushed/popped counts; clear returns both to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(push_cnt);
         rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
      end
   end

   // Expose the entries at the head of the buffer for the slot decoder.
   always_comb begin
      for (int i = 0; i < PEEK_W; i++) begin
         peek[i] = mem[rd_ptr[AW-1:0] + AW'(i)];
      end
   end

   assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/instr_aligner.sv
// Instruction aligner: compacts fetched halfwords into a buffer and emits up
// to NUM_UOPS aligned 16/32-bit instructions per cycle from the buffer head.
// Define RVC_EN to compile in 16-bit (compressed) instruction support; without
// it every instruction is a halfword pair and a non-32-bit low half is illegal.
module instr_aligner
   import instr_aligner_pkg::*;
#(
   parameter int NUM_UOPS  = 3,
   parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  IF_Instr       IN_instrs [FETCH_W],
   input  logic          IN_clear,
   input  logic          IN_ready,
   output logic          OUT_stall,
   output AlignedInstr_t OUT_instrs [NUM_UOPS]
);

`ifdef RVC_EN
   localparam bit RVC = 1'b1;
`else
   localparam bit RVC = 1'b0;
`endif

   localparam int PEEK_W  = 2 * NUM_UOPS;
   localparam int IDX_W   = $clog2(PEEK_W);
   localparam int FIDX_W  = $clog2(FETCH_W);
   localparam int PUSH_CW = $clog2(FETCH_W + 1);
   localparam int POP_CW  = $clog2(PEEK_W + 1);
   localparam int PTR_W   = $clog2(BUF_DEPTH) + 1;

   hw_entry_t          push_data [FETCH_W];
   logic [PUSH_CW-1:0] push_cnt;
   logic [POP_CW-1:0]  pop_cnt;
   logic [POP_CW-1:0]  consumed;
   hw_entry_t          peek [PEEK_W];
   logic [PTR_W-1:0]   count;

   hw_fifo #(
      .DEPTH   (BUF_DEPTH),
      .PUSH_W  (FETCH_W),
      .PEEK_W  (PEEK_W),
      .PUSH_CW (PUSH_CW),
      .POP_CW  (POP_CW),
      .PTR_W   (PTR_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (IN_clear),
      .push_cnt  (push_cnt),
      .push_data (push_data),
      .pop_cnt   (pop_cnt),
      .peek      (peek),
      .count     (count)
   );

   // Stall on pre-pop occupancy so a full fetch block always fits.
   assign OUT_stall = (BUF_DEPTH - int'(count)) < FETCH_W;

   // Compact valid halfwords in ascending index order; push only when not stalled.
   always_comb begin : compact
      int n;
      n = 0;
      for (int i = 0; i < FETCH_W; i++) begin
         push_data[i] = '0;
      end
      for (int i = 0; i < FETCH_W; i++) begin
         if (IN_instrs[i].valid) begin
            push_data[FIDX_W'(n)] = '{instr:     IN_instrs[i].instr,
                                      pc:        IN_instrs[i].pc,
                                      fetchID:   IN_instrs[i].fetchID,
                                      predTaken: IN_instrs[i].predTaken};
            n++;
         end
      end
      push_cnt = (n != 0 && !OUT_stall) ? PUSH_CW'(n) : '0;
   end

   // Walk the buffer head slot by slot; stop at a missing upper half or a taken prediction.
   always_comb begin : decode
      int            off;
      int            used;
      int            avail;
      logic          blocked;
      hw_entry_t     lo;
      logic [15:0]   hi_instr;
      logic [31:0]   hi_pc;
      logic          hi_pt;
      AlignedInstr_t slot;
      off      = 0;
      used     = 0;
      avail    = int'(count);
      blocked  = 1'b0;
      lo       = '0;
      hi_instr = '0;
      hi_pc    = '0;
      hi_pt    = 1'b0;
      slot     = '0;
      for (int k = 0; k < NUM_UOPS; k++) begin
         slot = '0;
         used = 0;
         if (!blocked && off < avail) begin
            lo           = peek[IDX_W'(off)];
            slot.pc      = lo.pc;
            slot.fetchID = lo.fetchID;
            if (RVC && lo.instr[1:0] != 2'b11) begin
               slot.valid      = 1'b1;
               slot.compressed = 1'b1;
               slot.instr      = {16'h0000, lo.instr};
               slot.predTaken  = lo.predTaken;
               used            = 1;
            end else if (off + 1 >= avail) begin
               // Upper half still in flight: hold this and every later slot.
               slot    = '0;
               blocked = 1'b1;
            end else begin
               hi_instr   = peek[IDX_W'(off + 1)].instr;
               hi_pc      = peek[IDX_W'(off + 1)].pc;
               hi_pt      = peek[IDX_W'(off + 1)].predTaken;
               slot.valid = 1'b1;
               if (hi_pc != lo.pc + 32'd2) begin
                  // Discontiguous halves: drop only the lower one.
                  slot.illegal   = 1'b1;
                  slot.predTaken = lo.predTaken;
                  used           = 1;
               end else if (lo.instr[1:0] != 2'b11) begin
                  slot.illegal   = 1'b1;
                  slot.predTaken = lo.predTaken | hi_pt;
                  used           = 2;
               end else begin
                  slot.instr     = {hi_instr, lo.instr};
                  slot.predTaken = lo.predTaken | hi_pt;
                  used           = 2;
               end
            end
            off += used;
            if (slot.valid && slot.predTaken) begin
               blocked = 1'b1;
            end
         end
         OUT_instrs[k] = slot;
      end
      consumed = POP_CW'(off);
   end

   assign pop_cnt = IN_ready ? consumed : '0;

endmodule

// File: tb/tb_instr_aligner.sv
// Directed and randomized bench for instr_aligner against a queue-based model.
module tb_instr_aligner;
   import instr_aligner_pkg::*;

   localparam int NU    = 3;
   localparam int DEPTH = 16;
`ifdef RVC_EN
   localparam bit RVC = 1'b1;
`else
   localparam bit RVC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   IF_Instr       in_i [FETCH_W];
   logic          clear;
   logic          ready;
   logic          stall;
   AlignedInstr_t out_i [NU];

   always #5 clk = ~clk;

   instr_aligner #(.NUM_UOPS(NU), .BUF_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .IN_instrs  (in_i),
      .IN_clear   (clear),
      .IN_ready   (ready),
      .OUT_stall  (stall),
      .OUT_instrs (out_i)
   );

   typedef struct {
      logic [15:0] hw;
      logic [31:0] pc;
      FetchID_t    fid;
      logic        pt;
   } mhw_t;

   mhw_t          q[$];
   AlignedInstr_t exp_o [NU];
   logic [15:0]   blk_hw [FETCH_W];
   int            vectors     = 0;
   int            miscompares = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
      vectors++;
      assert (obs === want) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Reference: read instructions off the front of the halfword queue.
   function automatic int model_decode();
      int p = 0;
      for (int k = 0; k < NU; k++) exp_o[k] = '0;
      for (int k = 0; k < NU; k++) begin
         mhw_t a;
         mhw_t b;
         if (p >= q.size()) break;
         a = q[p];
         if (RVC && a.hw[1:0] != 2'b11) begin
            exp_o[k] = '{instr: {16'h0, a.hw}, pc: a.pc, fetchID: a.fid, predTaken: a.pt,
                         compressed: 1'b1, illegal: 1'b0, valid: 1'b1};
            p += 1;
         end else begin
            if (p + 1 >= q.size()) break;
            b = q[p + 1];
            if (b.pc != a.pc + 32'd2) begin
               exp_o[k] = '{instr: 32'h0, pc: a.pc, fetchID: a.fid, predTaken: a.pt,
                            compressed: 1'b0, illegal: 1'b1, valid: 1'b1};
               p += 1;
            end else if (a.hw[1:0] != 2'b11) begin
               exp_o[k] = '{instr: 32'h0, pc: a.pc, fetchID: a.fid, predTaken: a.pt | b.pt,
                            compressed: 1'b0, illegal: 1'b1, valid: 1'b1};
               p += 2;
            end else begin
               exp_o[k] = '{instr: {b.hw, a.hw}, pc: a.pc, fetchID: a.fid, predTaken: a.pt | b.pt,
                            compressed: 1'b0, illegal: 1'b0, valid: 1'b1};
               p += 2;
            end
         end
         if (exp_o[k].predTaken) break;
      end
      return p;
   endfunction

   // Check this cycle's outputs, advance the model, move to the next cycle.
   task automatic step();
      int   used;
      logic exp_stall;
      used      = model_decode();
      exp_stall = (DEPTH - q.size()) < FETCH_W;
      chk("stall", stall, exp_stall);
      for (int k = 0; k < NU; k++) begin
         chk($sformatf("slot%0d.valid", k), out_i[k].valid, exp_o[k].valid);
         if (exp_o[k].valid) chk($sformatf("slot%0d", k), out_i[k], exp_o[k]);
      end
      if (clear) begin
         q.delete();
      end else begin
         if (ready) for (int i = 0; i < used; i++) void'(q.pop_front());
         if (!exp_stall) begin
            for (int i = 0; i < FETCH_W; i++) begin
               if (in_i[i].valid)
                  q.push_back('{hw: in_i[i].instr, pc: in_i[i].pc, fid: in_i[i].fetchID, pt: in_i[i].predTaken});
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_block(input logic [31:0] base, input logic [7:0] vm, input logic [7:0] pm,
                            input FetchID_t fid);
      for (int i = 0; i < FETCH_W; i++) begin
         in_i[i].instr     = blk_hw[i];
         in_i[i].pc        = base + 32'(2 * i);
         in_i[i].valid     = vm[i];
         in_i[i].fetchID   = fid;
         in_i[i].predTaken = pm[i];
      end
   endtask

   task automatic idle();
      for (int i = 0; i < FETCH_W; i++) in_i[i] = '0;
   endtask

   task automatic four_wide();
      blk_hw = '{16'h0513, 16'h00A0, 16'h0593, 16'h00B0, 16'h0613, 16'h00C0, 16'h0693, 16'h00D0};
   endtask

   initial begin
      logic [31:0] rpc;
      FetchID_t    fid;
      rst   = 1'b0;
      clear = 1'b0;
      ready = 1'b1;
      four_wide();
      set_block(32'h40, 8'hFF, 8'h00, 4'd0);
      repeat (2) @(posedge clk);
      #1;
      // Reset state while a block is offered.
      chk("rst_stall", stall, 1'b0);
      for (int k = 0; k < NU; k++) chk($sformatf("rst_valid%0d", k), out_i[k].valid, 1'b0);
      rst = 1'b1;
      idle();
      step();

      // Four 32-bit instructions at 0x100..0x10E.
      four_wide();
      set_block(32'h100, 8'hFF, 8'h00, 4'd1);
      step();
      idle();
      chk("r29_pc0", out_i[0].pc, 32'h100);
      chk("r29_pc1", out_i[1].pc, 32'h104);
      chk("r29_pc2", out_i[2].pc, 32'h108);
      chk("r29_in0", out_i[0].instr, 32'h00A00513);
      step();
      chk("r29_next_pc", out_i[0].pc, 32'h10C);
      chk("r29_next_v1", out_i[1].valid, 1'b0);
      step();

      // Compressed followed by a 32-bit instruction.
      blk_hw = '{16'h4501, 16'h0513, 16'h00A0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      set_block(32'h100, 8'h07, 8'h00, 4'd2);
      step();
      idle();
`ifdef RVC_EN
      chk("r30_cmp0", out_i[0].compressed, 1'b1);
      chk("r30_pc0", out_i[0].pc, 32'h100);
      chk("r30_in1", out_i[1].instr, 32'h00A00513);
      chk("r30_pc1", out_i[1].pc, 32'h102);
`endif
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;

      // Lower half at the end of one block, upper half in the next.
      blk_hw = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0513};
      set_block(32'h110, 8'h80, 8'h00, 4'd3);
      step();
      idle();
      chk("r31_wait", out_i[0].valid, 1'b0);
      step();
      blk_hw = '{16'h00A0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      set_block(32'h120, 8'h01, 8'h00, 4'd4);
      step();
      idle();
      chk("r31_pc", out_i[0].pc, 32'h11E);
      chk("r31_instr", out_i[0].instr, 32'h00A00513);
      chk("r31_v1", out_i[1].valid, 1'b0);
      step();

      // Decode back-pressure with blocks arriving.
      ready = 1'b0;
      four_wide();
      set_block(32'h200, 8'hFF, 8'h00, 4'd5);
      step();
      set_block(32'h210, 8'hFF, 8'h00, 4'd6);
      step();
      chk("r32_stall", stall, 1'b1);
      set_block(32'h220, 8'hFF, 8'h00, 4'd7);
      step();
      ready = 1'b1;
      idle();
      repeat (4) step();
      chk("r32_drained", out_i[0].valid, 1'b0);

      // Clear with a half instruction buffered and a block offered.
      blk_hw = '{16'h0513, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      set_block(32'h300, 8'h01, 8'h00, 4'd8);
      step();
      four_wide();
      set_block(32'h310, 8'hFF, 8'h00, 4'd9);
      clear = 1'b1;
      step();
      clear = 1'b0;
      idle();
      chk("r33_v0", out_i[0].valid, 1'b0);
      chk("r33_stall", stall, 1'b0);
      step();
      chk("r33_dropped", out_i[0].valid, 1'b0);

      // Taken prediction on slot 1 with more instructions behind.
      four_wide();
      set_block(32'h400, 8'hFF, 8'h04, 4'd10);
      step();
      idle();
      chk("r34_pt1", out_i[1].predTaken, 1'b1);
      chk("r34_v2", out_i[2].valid, 1'b0);
      step();
      chk("r34_next_pc", out_i[0].pc, 32'h408);
      repeat (2) step();

      // Reset asserted with a partial instruction buffered.
      blk_hw = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0513};
      set_block(32'h500, 8'h80, 8'h00, 4'd11);
      step();
      four_wide();
      set_block(32'h600, 8'hFF, 8'h00, 4'd12);
      #2;
      rst = 1'b0;
      #1;
      chk("r24_v0", out_i[0].valid, 1'b0);
      chk("r24_stall", stall, 1'b0);
      q.delete();
      @(posedge clk);
      #1;
      chk("r24_hold", out_i[0].valid, 1'b0);
      rst = 1'b1;
      idle();
      step();
      step();

      // Randomized traffic.
      rpc = 32'h1000;
      fid = 4'd0;
      for (int n = 0; n < 400; n++) begin
         int          lo;
         int          hi;
         logic [7:0]  vm;
         logic [7:0]  pm;
         logic        acc;
         ready = ($urandom % 4) != 0;
         clear = ($urandom % 25) == 0;
         if ($urandom % 10 == 0) rpc += 32'(2 * $urandom_range(1, 8));
         lo = $urandom_range(0, 7);
         hi = $urandom_range(lo, 7);
         vm = '0;
         pm = '0;
         for (int i = 0; i < FETCH_W; i++) begin
            blk_hw[i] = 16'($urandom);
            if ($urandom % 3 != 0) blk_hw[i][1:0] = 2'b11;
            if (i >= lo && i <= hi) vm[i] = 1'b1;
            if ($urandom % 12 == 0) pm[i] = 1'b1;
         end
         if ($urandom % 10 == 0) vm = '0;
         set_block(rpc - 32'(2 * lo), vm, pm, fid);
         acc = !clear && vm != 0 && (DEPTH - q.size()) >= FETCH_W;
         step();
         if (acc) begin
            rpc += 32'(2 * (hi - lo + 1));
            fid++;
         end
      end

      idle();
      clear = 1'b0;
      ready = 1'b1;
      repeat (8) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
